flowing_light_multi: RTL
========================

Name: flowing_light_multi

Overview:
- Parametrised successor of the EGO1 single-pattern flowing light.
- Drives an N_LED-wide LED bank from a programmable-rate step generator.
- Supports four run-time selectable patterns, pause and four speed settings.
- Emits step/wrap pulses so that a seven-segment or buzzer block can be synchronised to the pattern.

Parameters:
- N_LED, 16, number of LEDs driven; legal range 2..32.
- TICK_MAX, 100000000, base step interval limit in clk cycles; set to 10 for simulation.
- CNT_W, 28, prescaler width; must satisfy 2^CNT_W > TICK_MAX.

Ports:
- clk  input  1  system clock, 100 MHz on EGO1
- rst  input  1  asynchronous, active-low reset
- en  input  1  1 = run; 0 = pause, with the pattern and prescaler held
- mode  input  2  0 ROT_R, 1 ROT_L, 2 BOUNCE, 3 BAR
- speed  input  2  step limit L = TICK_MAX >> speed
- led  output  N_LED  pattern register, bit N_LED-1 = leftmost LED
- step  output  1  one-cycle pulse, high in the cycle after led advances
- wrap  output  1  one-cycle pulse, high together with step when the pattern returns to its seed

Behaviour:
- Reset (rst low, asynchronous):
  - cnt = 0, mode_q = 0, dir = right.
  - led = 1 << (N_LED-1), e.g. 16'h8000.
  - step = 0, wrap = 0.
- Prescaler:
  - While en = 1, cnt increments each cycle; when cnt == L, cnt -> 0 and a tick occurs.
  - Step period is L+1 cycles.
  - While en = 0, cnt holds and no tick occurs.
- Speed change: if cnt > new L, cnt -> 0 on the next edge with no tick; otherwise counting continues to the new L.
- Mode change:
  - mode_q registers mode each cycle; when mode != mode_q, the next edge loads the new mode's seed, cnt -> 0 and dir -> right.
  - No step/wrap is produced that cycle.
  - Mode change has priority over a simultaneous tick and applies even while en = 0.
- Seeds:
  - ROT_R and BOUNCE: 1 << (N_LED-1).
  - ROT_L: 1.
  - BAR: all zeros.
- Per-tick update:
  - ROT_R: logical right shift; from bit 0 wraps to MSB. wrap = 1 on the transition into the seed.
  - ROT_L: left shift; from MSB wraps to bit 0. wrap = 1 on the transition into the seed.
  - BOUNCE:
    - dir right: shift right; on reaching bit 0, dir flips left.
    - dir left: shift left; on reaching the MSB, dir flips right and wrap = 1.
    - Endpoints are shown for exactly one step, with no double dwell. Period is 2*(N_LED-1) steps.
  - BAR:
    - led <= {1'b1, led[N_LED-1:1]} (fills from the left).
    - All ones -> all zeros, with wrap = 1.
    - Period is N_LED+1 steps.
- step and wrap are registered and are high for exactly the one cycle following the led update.
- led is always one-hot in ROT/BOUNCE and thermometer-coded in BAR; no other value is ever driven.
- All state updates occur on the rising clk edge, except reset.

Test Plan:
- Reset: TICK_MAX=10, N_LED=16, mode=0, speed=0, en=1; release rst.
  - Expect led=16'h8000, then 16'h4000 after 11 cycles, step pulses every 11 cycles.
  - After 16 steps expect led=16'h8000 with wrap=1 on that step only.
- ROT_L / BAR wrap:
  - mode=1: led loads 16'h0001 one cycle after the change; after step 15 expect 16'h8000; after step 16 expect 16'h0001 with wrap=1.
  - mode=3: sequence 0000, 8000, C000, ..., FFFF, 0000 with wrap=1 at FFFF -> 0000 (17-step period).
- BOUNCE with N_LED=4:
  - Sequence 1000, 0100, 0010, 0001, 0010, 0100, 1000 (wrap=1), 0100.
  - No repeated endpoint value.
- Speed/pause:
  - speed=1: step period is 6 cycles.
  - Switch speed 0 -> 2 when cnt=8: cnt clears, no step that cycle, subsequent period is 3 cycles.
  - en=0 for 50 cycles: led, cnt stable and no steps; en=1 resumes from the held cnt.
- Simultaneous events and async reset:
  - Change mode in the same cycle cnt==L: seed loads, step=0, wrap=0.
  - Assert rst mid-period, asynchronously between edges: led=16'h8000 immediately, cnt=0, step=0.

Source files
------------

// File: rtl/flowing_light_multi.sv
// rtl/flowing_light_multi.sv - multi-pattern flowing light with programmable step rate
// Four patterns (rotate right/left, bounce, bar fill), pause and four speeds; step/wrap for sync.
module flowing_light_multi #(
  parameter int N_LED    = 16,
  parameter int TICK_MAX = 100000000,
  parameter int CNT_W    = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam logic [1:0] ROT_R  = 2'd0;
  localparam logic [1:0] ROT_L  = 2'd1;
  localparam logic [1:0] BOUNCE = 2'd2;
  localparam logic [1:0] BAR    = 2'd3;

  localparam logic [CNT_W-1:0] LIM_BASE = CNT_W'(TICK_MAX);
  localparam logic [N_LED-1:0] MSB_ONE  = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [N_LED-1:0] LSB_ONE  = {{(N_LED-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode_q;
  logic             r_dir_left;
  logic [N_LED-1:0] r_led;
  logic             r_step;
  logic             r_wrap;

  logic [CNT_W-1:0] w_lim;
  logic             w_mode_chg;
  logic [N_LED-1:0] w_seed;
  logic [N_LED-1:0] w_next;
  logic             w_next_wrap;
  logic             w_next_dir_left;

  assign w_lim      = LIM_BASE >> speed;
  assign w_mode_chg = (mode != r_mode_q);

  // Seed follows the incoming mode, since r_mode_q still holds the old one on the load edge.
  always_comb begin
    w_seed = MSB_ONE;
    case (mode)
      ROT_L:   w_seed = LSB_ONE;
      BAR:     w_seed = '0;
      default: w_seed = MSB_ONE;
    endcase
  end

  always_comb begin
    w_next          = r_led;
    w_next_wrap     = 1'b0;
    w_next_dir_left = r_dir_left;
    case (r_mode_q)
      ROT_R: begin
        w_next      = {r_led[0], r_led[N_LED-1:1]};
        w_next_wrap = r_led[0];
      end
      ROT_L: begin
        w_next      = {r_led[N_LED-2:0], r_led[N_LED-1]};
        w_next_wrap = r_led[N_LED-1];
      end
      BOUNCE: begin
        // Direction flips on the step that lands on an endpoint, so each endpoint shows once.
        if (!r_dir_left) begin
          w_next          = r_led >> 1;
          w_next_dir_left = r_led[1];
        end else begin
          w_next          = r_led << 1;
          w_next_dir_left = !r_led[N_LED-2];
          w_next_wrap     = r_led[N_LED-2];
        end
      end
      default: begin
        if (&r_led) begin
          w_next      = '0;
          w_next_wrap = 1'b1;
        end else begin
          w_next = {1'b1, r_led[N_LED-1:1]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_mode_q   <= ROT_R;
      r_dir_left <= 1'b0;
      r_led      <= MSB_ONE;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_mode_q <= mode;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      if (w_mode_chg) begin
        r_led      <= w_seed;
        r_cnt      <= '0;
        r_dir_left <= 1'b0;
      end else if (en) begin
        if (r_cnt > w_lim) begin
          r_cnt <= '0;
        end else if (r_cnt == w_lim) begin
          r_cnt      <= '0;
          r_led      <= w_next;
          r_dir_left <= w_next_dir_left;
          r_step     <= 1'b1;
          r_wrap     <= w_next_wrap;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign led  = r_led;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule
